// File: rtl/bank_distributor.sv
// Distributes N input lanes across N memory banks with an address-dependent
// rotation; outputs are registered and write strobes drop for out-of-range addresses.
module bank_distributor #(
  parameter int CHANNEL_NUMBER    = 3,
  parameter int CHANNEL_BANDWIDTH = 8,
  parameter int BLOCK_DEPTH       = 12,
  localparam int CHANNEL_DEPTH    = BLOCK_DEPTH / CHANNEL_NUMBER,
  localparam int GLOBAL_ADDR_BITS = $clog2(BLOCK_DEPTH),
  localparam int BANK_ADDR_BITS   = $clog2(BLOCK_DEPTH)
) (
  input  logic                         I_clk_in,
  input  logic                         I_rst_n,
  input  logic [CHANNEL_BANDWIDTH-1:0] I_data_in     [0:CHANNEL_NUMBER-1],
  input  logic [GLOBAL_ADDR_BITS-1:0]  I_address_in,
  output logic [CHANNEL_BANDWIDTH-1:0] O_data_out    [0:CHANNEL_NUMBER-1],
  output logic [BANK_ADDR_BITS-1:0]    O_address_out [0:CHANNEL_NUMBER-1],
  output logic                         O_clk_out     [0:CHANNEL_NUMBER-1]
);

  int                           addr_int;
  int                           rot_int;
  int                           ba_int;
  logic                         in_range;
  logic [CHANNEL_BANDWIDTH-1:0] data_d [0:CHANNEL_NUMBER-1];
  logic [BANK_ADDR_BITS-1:0]    addr_d;

  logic [CHANNEL_BANDWIDTH-1:0] data_q [0:CHANNEL_NUMBER-1];
  logic [BANK_ADDR_BITS-1:0]    addr_q;
  logic                         strobe_q;

  // Lane i lands in bank (i + rot) mod N; the loop form keeps every index constant.
  always_comb begin
    addr_int = int'(I_address_in);
    rot_int  = addr_int % CHANNEL_NUMBER;
    ba_int   = addr_int / CHANNEL_NUMBER;
    in_range = (addr_int < CHANNEL_DEPTH * CHANNEL_NUMBER);
    addr_d   = BANK_ADDR_BITS'(ba_int);
    for (int b = 0; b < CHANNEL_NUMBER; b++) begin
      data_d[b] = '0;
      for (int i = 0; i < CHANNEL_NUMBER; i++) begin
        if (((i + rot_int) % CHANNEL_NUMBER) == b) begin
          data_d[b] = I_data_in[i];
        end
      end
    end
  end

  // Out-of-range samples only clear the strobe; data and address keep their last values.
  always_ff @(posedge I_clk_in or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int b = 0; b < CHANNEL_NUMBER; b++) begin
        data_q[b] <= '0;
      end
      addr_q   <= '0;
      strobe_q <= 1'b0;
    end else if (in_range) begin
      for (int b = 0; b < CHANNEL_NUMBER; b++) begin
        data_q[b] <= data_d[b];
      end
      addr_q   <= addr_d;
      strobe_q <= 1'b1;
    end else begin
      strobe_q <= 1'b0;
    end
  end

  always_comb begin
    for (int b = 0; b < CHANNEL_NUMBER; b++) begin
      O_data_out[b]    = data_q[b];
      O_address_out[b] = addr_q;
      O_clk_out[b]     = strobe_q;
    end
  end

endmodule

// File: tb/tb_bank_distributor.sv
// Directed and random checks of bank_distributor against a reference model
// feeding an expected-output queue.
module tb_bank_distributor;
  localparam int N = 3;
  localparam int W = 8;
  localparam int D = 12;
  localparam int G = $clog2(D);
  localparam int A = $clog2(D);

  typedef struct packed {
    logic [N-1:0][W-1:0] data;
    logic [N-1:0][A-1:0] addr;
    logic [N-1:0]        strb;
  } out_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in  [0:N-1];
  logic [G-1:0] addr_in;
  logic [W-1:0] data_out [0:N-1];
  logic [A-1:0] addr_out [0:N-1];
  logic         clk_out  [0:N-1];

  out_t exp_q[$];
  out_t model;
  int   n_cmp = 0;
  int   n_bad = 0;

  bank_distributor #(
    .CHANNEL_NUMBER(N), .CHANNEL_BANDWIDTH(W), .BLOCK_DEPTH(D)
  ) dut (
    .I_clk_in(clk),
    .I_rst_n(rst_n),
    .I_data_in(data_in),
    .I_address_in(addr_in),
    .O_data_out(data_out),
    .O_address_out(addr_out),
    .O_clk_out(clk_out)
  );

  always #5 clk = ~clk;

  function automatic out_t sample_dut();
    out_t s;
    for (int b = 0; b < N; b++) begin
      s.data[b] = data_out[b];
      s.addr[b] = addr_out[b];
      s.strb[b] = clk_out[b];
    end
    return s;
  endfunction

  task automatic compare(input string tag, input out_t act, input out_t exp);
    n_cmp++;
    assert (act.data === exp.data) else begin
      n_bad++;
      $error("FAIL %s data: got %h want %h", tag, act.data, exp.data);
    end
    n_cmp++;
    assert (act.addr === exp.addr) else begin
      n_bad++;
      $error("FAIL %s addr: got %h want %h", tag, act.addr, exp.addr);
    end
    n_cmp++;
    assert (act.strb === exp.strb) else begin
      n_bad++;
      $error("FAIL %s strobe: got %b want %b", tag, act.strb, exp.strb);
    end
  endtask

  task automatic predict(input logic [G-1:0] a, input logic [N-1:0][W-1:0] d);
    int ai;
    int rot;
    ai = int'(a);
    if (ai < D) begin
      rot = ai % N;
      for (int i = 0; i < N; i++) model.data[(i + rot) % N] = d[i];
      for (int b = 0; b < N; b++) model.addr[b] = A'(ai / N);
      model.strb = '1;
    end else begin
      model.strb = '0;
    end
  endtask

  task automatic check_pop(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s queue: got empty want entry", tag);
    end else begin
      compare(tag, sample_dut(), exp_q.pop_front());
    end
  endtask

  task automatic step(input logic [G-1:0] a, input logic [N-1:0][W-1:0] d, input string tag);
    @(negedge clk);
    addr_in = a;
    for (int i = 0; i < N; i++) data_in[i] = d[i];
    predict(a, d);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  task automatic check_lit(input string tag, input logic [N-1:0][W-1:0] d,
                           input logic [A-1:0] a, input logic s);
    out_t e;
    e.data = d;
    for (int b = 0; b < N; b++) e.addr[b] = a;
    e.strb = {N{s}};
    compare(tag, sample_dut(), e);
  endtask

  initial begin
    logic [N-1:0][W-1:0] d0;
    logic [N-1:0][W-1:0] rd;
    d0 = {8'h00, 8'h55, 8'hFF};
    model = '0;
    addr_in = '0;
    for (int i = 0; i < N; i++) data_in[i] = '0;

    #1;
    compare("reset_async", sample_dut(), '0);
    repeat (2) @(posedge clk);
    #1;
    compare("reset_hold", sample_dut(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    step(4'd0, d0, "addr0");
    check_lit("addr0_lit", {8'h00, 8'h55, 8'hFF}, 4'd0, 1'b1);
    step(4'd1, d0, "addr1");
    check_lit("addr1_lit", {8'h55, 8'hFF, 8'h00}, 4'd0, 1'b1);
    step(4'd5, d0, "addr5");
    check_lit("addr5_lit", {8'hFF, 8'h00, 8'h55}, 4'd1, 1'b1);
    step(4'd11, d0, "addr11");
    check_lit("addr11_lit", {8'hFF, 8'h00, 8'h55}, 4'd3, 1'b1);

    for (int a = 0; a < D; a++) step(G'(a), d0, "sweep");
    step(4'd13, d0, "oor13");
    check_lit("oor13_lit", {8'hFF, 8'h00, 8'h55}, 4'd3, 1'b0);
    step(4'd15, {8'h12, 8'h34, 8'h56}, "oor15_hold");
    step(4'd0, {8'h12, 8'h34, 8'h56}, "wrap_back");
    step(4'd11, {8'hA1, 8'hB2, 8'hC3}, "wrap_hi");
    step(4'd0, {8'hA1, 8'hB2, 8'hC3}, "wrap_lo");

    for (int a = 0; a < 4; a++) step(G'(a), d0, "pre_reset");
    @(negedge clk);
    addr_in = 4'd4;
    #2;
    rst_n = 1'b0;
    #1;
    compare("midreset_async", sample_dut(), '0);
    @(posedge clk);
    #1;
    compare("midreset_hold", sample_dut(), '0);
    model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    addr_in = 4'd0;
    for (int i = 0; i < N; i++) data_in[i] = d0[i];
    predict(4'd0, d0);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    check_pop("post_reset");
    check_lit("post_reset_lit", {8'h00, 8'h55, 8'hFF}, 4'd0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) rd[i] = W'($urandom_range(0, 255));
      step(G'($urandom_range(0, 15)), rd, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
